// File: rtl/instr_reader_exec.sv
// instr_reader_exec: read-side consumer for the instruction register.
// Walks a programmed range of locations, executes each instruction word and
// presents one result per location on a valid/ready port.
module instr_reader_exec #(
    parameter int unsigned DEPTH = 32,
    parameter int unsigned OPW   = 32,
    localparam int unsigned PW   = $clog2(DEPTH),
    localparam int unsigned RW   = 2 * OPW
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_start,
    input  logic [PW-1:0] i_start_ptr,
    input  logic [PW:0]   i_count,
    output logic [PW-1:0] o_read_pointer,
    input  logic [3:0]    i_iw_opc,
    input  logic [OPW-1:0] i_iw_op_a,
    input  logic [OPW-1:0] i_iw_op_b,
    output logic          o_busy,
    output logic          o_res_valid,
    input  logic          i_res_ready,
    output logic [RW-1:0] o_res_data,
    output logic [PW-1:0] o_res_addr,
    output logic [3:0]    o_res_opc,
    output logic          o_res_err,
    output logic          o_done
);

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StExec,
        StResp
    } state_t;

    state_t         r_state;
    logic [PW-1:0]  r_rd_ptr;
    logic [PW:0]    r_remain;
    logic [3:0]     r_opc;
    logic [OPW-1:0] r_a;
    logic [OPW-1:0] r_b;
    logic [PW-1:0]  r_cur_addr;
    logic           r_res_valid;
    logic [RW-1:0]  r_res_data;
    logic [PW-1:0]  r_res_addr;
    logic [3:0]     r_res_opc;
    logic           r_res_err;
    logic           r_done;

    logic signed [RW-1:0] w_a;
    logic signed [RW-1:0] w_b;
    logic signed [RW-1:0] w_res;
    logic                 w_err;
    logic [PW-1:0]        w_next_ptr;
    logic                 w_b_zero;

    // Operands sign-extended to the result width so every opcode is exact.
    assign w_a      = {{OPW{r_a[OPW-1]}}, r_a};
    assign w_b      = {{OPW{r_b[OPW-1]}}, r_b};
    assign w_b_zero = (r_b == '0);

    // Pointer advance wraps at DEPTH even when DEPTH is not a power of two.
    assign w_next_ptr = (r_rd_ptr == PW'(DEPTH - 1)) ? '0 : r_rd_ptr + PW'(1);

    // Execute the captured opcode; divide/mod by zero and undefined opcodes flag an error.
    always_comb begin
        w_res = '0;
        w_err = 1'b0;
        case (r_opc)
            4'd0: w_res = '0;
            4'd1: w_res = w_a;
            4'd2: w_res = w_b;
            4'd3: w_res = w_a + w_b;
            4'd4: w_res = w_a - w_b;
            4'd5: w_res = w_a * w_b;
            4'd6: begin
                if (w_b_zero) w_err = 1'b1;
                else          w_res = w_a / w_b;
            end
            4'd7: begin
                if (w_b_zero) w_err = 1'b1;
                else          w_res = w_a % w_b;
            end
            default: w_err = 1'b1;
        endcase
    end

    // Sequencing FSM with all outputs registered; reset aborts any sequence in flight.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state     <= StIdle;
            r_rd_ptr    <= '0;
            r_remain    <= '0;
            r_opc       <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_cur_addr  <= '0;
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
            r_res_addr  <= '0;
            r_res_opc   <= '0;
            r_res_err   <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (i_start) begin
                        r_rd_ptr <= i_start_ptr;
                        r_remain <= i_count;
                        if (i_count == '0) r_done  <= 1'b1;
                        else               r_state <= StFetch;
                    end
                end
                StFetch: begin
                    r_opc      <= i_iw_opc;
                    r_a        <= i_iw_op_a;
                    r_b        <= i_iw_op_b;
                    r_cur_addr <= r_rd_ptr;
                    r_state    <= StExec;
                end
                StExec: begin
                    r_res_data  <= w_res;
                    r_res_err   <= w_err;
                    r_res_opc   <= r_opc;
                    r_res_addr  <= r_cur_addr;
                    r_res_valid <= 1'b1;
                    r_state     <= StResp;
                end
                StResp: begin
                    if (i_res_ready) begin
                        r_res_valid <= 1'b0;
                        r_remain    <= r_remain - (PW + 1)'(1);
                        if (r_remain == (PW + 1)'(1)) begin
                            r_done  <= 1'b1;
                            r_state <= StIdle;
                        end else begin
                            r_rd_ptr <= w_next_ptr;
                            r_state  <= StFetch;
                        end
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign o_read_pointer = r_rd_ptr;
    assign o_busy         = (r_state != StIdle);
    assign o_res_valid    = r_res_valid;
    assign o_res_data     = r_res_data;
    assign o_res_addr     = r_res_addr;
    assign o_res_opc      = r_res_opc;
    assign o_res_err      = r_res_err;
    assign o_done         = r_done;

endmodule

// File: tb/tb_instr_reader_exec.sv
// Bench for instr_reader_exec: scenario tasks with randomized instruction contents
// checked against an arithmetic reference model of the opcode table.
module tb_instr_reader_exec;

    localparam int DEPTH = 32;
    localparam int OPW   = 32;
    localparam int PW    = 5;

    logic          clk = 1'b0;
    logic          i_reset;
    logic          i_start;
    logic [PW-1:0] i_start_ptr;
    logic [PW:0]   i_count;
    logic [PW-1:0] o_read_pointer;
    logic [3:0]    iw_opc;
    logic [31:0]   iw_a;
    logic [31:0]   iw_b;
    logic          o_busy;
    logic          o_res_valid;
    logic          i_res_ready;
    logic [63:0]   o_res_data;
    logic [PW-1:0] o_res_addr;
    logic [3:0]    o_res_opc;
    logic          o_res_err;
    logic          o_done;

    // Instruction register model, read combinationally at the DUT's pointer.
    logic [3:0]  mem_opc [DEPTH];
    logic [31:0] mem_a   [DEPTH];
    logic [31:0] mem_b   [DEPTH];

    assign iw_opc = mem_opc[o_read_pointer];
    assign iw_a   = mem_a[o_read_pointer];
    assign iw_b   = mem_b[o_read_pointer];

    always #5 clk = ~clk;

    instr_reader_exec #(.DEPTH(DEPTH), .OPW(OPW)) dut (
        .i_clk          (clk),
        .i_reset        (i_reset),
        .i_start        (i_start),
        .i_start_ptr    (i_start_ptr),
        .i_count        (i_count),
        .o_read_pointer (o_read_pointer),
        .i_iw_opc       (iw_opc),
        .i_iw_op_a      (iw_a),
        .i_iw_op_b      (iw_b),
        .o_busy         (o_busy),
        .o_res_valid    (o_res_valid),
        .i_res_ready    (i_res_ready),
        .o_res_data     (o_res_data),
        .o_res_addr     (o_res_addr),
        .o_res_opc      (o_res_opc),
        .o_res_err      (o_res_err),
        .o_done         (o_done)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Observations gathered by collect().
    logic [63:0] obs_data [$];
    int          obs_addr [$];
    int          obs_opc  [$];
    logic        obs_err  [$];
    int          acc_cyc  [$];
    int          first_valid_cyc;
    int          done_cnt;
    int          done_cyc;
    logic        busy_at_done;
    int          unstable;
    bit          timed_out;

    // Reference: opcode table evaluated with 64-bit integer arithmetic.
    function automatic void model(input logic [3:0] opc, input logic [31:0] a,
                                  input logic [31:0] b, output logic [63:0] d,
                                  output logic e);
        longint la, lb, ma, mb, q;
        la = $signed(a);
        lb = $signed(b);
        d  = '0;
        e  = 1'b0;
        q  = 0;
        if (opc > 4'd7 || ((opc == 4'd6 || opc == 4'd7) && lb == 0)) begin
            e = 1'b1;
        end else begin
            if (opc == 4'd6 || opc == 4'd7) begin
                ma = (la < 0) ? -la : la;
                mb = (lb < 0) ? -lb : lb;
                q  = ma / mb;
                if ((la < 0) != (lb < 0)) q = -q;
            end
            case (opc)
                4'd1:    d = la;
                4'd2:    d = lb;
                4'd3:    d = la + lb;
                4'd4:    d = la - lb;
                4'd5:    d = la * lb;
                4'd6:    d = q;
                4'd7:    d = la - q * lb;
                default: d = '0;
            endcase
        end
    endfunction

    task automatic set_loc(input int ad, input logic [3:0] opc, input logic [31:0] a,
                           input logic [31:0] b);
        mem_opc[ad] = opc;
        mem_a[ad]   = a;
        mem_b[ad]   = b;
    endtask

    task automatic do_start(input int ptr, input int cnt);
        @(negedge clk);
        i_start     = 1'b1;
        i_start_ptr = ptr[PW-1:0];
        i_count     = cnt[PW:0];
        @(negedge clk);
        i_start = 1'b0;
    endtask

    // Runs the result port for n results (stall_pct percent of cycles not ready),
    // recording accepted results and timing. Optionally pulses start while busy.
    task automatic collect(input int n, input int stall_pct, input bit busy_pulse);
        int          cyc;
        int          last_acc;
        bit          have_prev;
        logic [63:0] pd;
        logic [PW-1:0] pa;
        logic [3:0]  po;
        logic        pe;
        obs_data.delete(); obs_addr.delete(); obs_opc.delete(); obs_err.delete();
        acc_cyc.delete();
        first_valid_cyc = -1; done_cnt = 0; done_cyc = -1; busy_at_done = 1'bx;
        unstable = 0; timed_out = 1'b0;
        cyc = 0; last_acc = -100; have_prev = 1'b0;
        pd = '0; pa = '0; po = '0; pe = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            i_start = busy_pulse && (cyc == 3);
            if (i_start) begin
                i_start_ptr = 5'd9;
                i_count     = 6'd5;
            end
            if (o_done) begin
                done_cnt++;
                done_cyc     = cyc;
                busy_at_done = o_busy;
            end
            if (o_res_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (have_prev && (!o_res_valid || o_res_data !== pd || o_res_addr !== pa ||
                              o_res_opc !== po || o_res_err !== pe))
                unstable++;
            have_prev = 1'b0;
            if (obs_data.size() >= n && cyc >= last_acc + 3) break;
            if (cyc > 600) begin
                timed_out = 1'b1;
                break;
            end
            i_res_ready = ($urandom_range(99) >= stall_pct);
            if (o_res_valid) begin
                if (i_res_ready) begin
                    obs_data.push_back(o_res_data);
                    obs_addr.push_back(int'(o_res_addr));
                    obs_opc.push_back(int'(o_res_opc));
                    obs_err.push_back(o_res_err);
                    acc_cyc.push_back(cyc);
                    last_acc = cyc;
                end else begin
                    have_prev = 1'b1;
                    pd = o_res_data; pa = o_res_addr; po = o_res_opc; pe = o_res_err;
                end
            end
        end
        i_start     = 1'b0;
        i_res_ready = 1'b1;
    endtask

    task automatic test_reset();
        i_reset = 1'b1; i_start = 1'b0; i_start_ptr = '0; i_count = '0; i_res_ready = 1'b1;
        repeat (3) @(negedge clk);
        i_reset = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({o_read_pointer, o_busy, o_res_valid, o_done} !== '0) begin
            n_fail++;
            $display("FAIL reset_ctl: ptr=%0d busy=%b valid=%b done=%b, want all 0",
                     o_read_pointer, o_busy, o_res_valid, o_done);
        end
        n_cmp++;
        if ({o_res_data, o_res_addr, o_res_opc, o_res_err} !== '0) begin
            n_fail++;
            $display("FAIL reset_res: data=%h addr=%0d opc=%0d err=%b, want all 0",
                     o_res_data, o_res_addr, o_res_opc, o_res_err);
        end
    endtask

    task automatic test_basic();
        logic [63:0] exp_d [3];
        exp_d[0] = 64'd8;
        exp_d[1] = -64'sd9;
        exp_d[2] = -64'sd24;
        set_loc(0, 4'd3, 32'd5, 32'd3);
        set_loc(1, 4'd4, -32'sd7, 32'd2);
        set_loc(2, 4'd5, -32'sd4, 32'd6);
        do_start(0, 3);
        n_cmp++;
        if (o_read_pointer !== 5'd0 || o_busy !== 1'b1 || o_res_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_after_e0: ptr=%0d busy=%b valid=%b, want 0/1/0",
                     o_read_pointer, o_busy, o_res_valid);
        end
        collect(3, 0, 1'b0);
        n_cmp++;
        if (timed_out || obs_data.size() != 3) begin
            n_fail++;
            $display("FAIL basic_count: got %0d results (timeout=%b), want 3",
                     obs_data.size(), timed_out);
        end
        for (int i = 0; i < 3 && i < obs_data.size(); i++) begin
            n_cmp++;
            if (obs_data[i] !== exp_d[i] || obs_addr[i] != i || obs_err[i] !== 1'b0) begin
                n_fail++;
                $display("FAIL basic_res[%0d]: data=%h addr=%0d err=%b, want %h/%0d/0",
                         i, obs_data[i], obs_addr[i], obs_err[i], exp_d[i], i);
            end
        end
        n_cmp++;
        if (first_valid_cyc != 2) begin
            n_fail++;
            $display("FAIL basic_latency: first valid %0d cycles after start, want 2",
                     first_valid_cyc);
        end
        for (int i = 1; i < acc_cyc.size(); i++) begin
            n_cmp++;
            if (acc_cyc[i] - acc_cyc[i-1] != 3) begin
                n_fail++;
                $display("FAIL basic_rate[%0d]: spacing %0d, want 3",
                         i, acc_cyc[i] - acc_cyc[i-1]);
            end
        end
        n_cmp++;
        if (acc_cyc.size() != 3 || done_cnt != 1 || done_cyc != acc_cyc[2] + 1 ||
            busy_at_done !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_done: pulses=%0d at=%0d busy=%b, want 1 pulse after last, busy 0",
                     done_cnt, done_cyc, busy_at_done);
        end
    endtask

    task automatic test_errors();
        logic [63:0] exp_d [3];
        logic        exp_e [3];
        exp_d[0] = '0;     exp_e[0] = 1'b1;
        exp_d[1] = -64'sd1; exp_e[1] = 1'b0;
        exp_d[2] = '0;     exp_e[2] = 1'b1;
        set_loc(4, 4'd6, 32'd7, 32'd0);
        set_loc(5, 4'd7, -32'sd7, 32'd2);
        set_loc(6, 4'd12, $urandom, $urandom);
        do_start(4, 3);
        collect(3, 0, 1'b0);
        n_cmp++;
        if (obs_data.size() != 3 || done_cnt != 1) begin
            n_fail++;
            $display("FAIL err_count: results=%0d done=%0d, want 3/1", obs_data.size(), done_cnt);
        end
        for (int i = 0; i < 3 && i < obs_data.size(); i++) begin
            n_cmp++;
            if (obs_data[i] !== exp_d[i] || obs_err[i] !== exp_e[i] || obs_addr[i] != 4 + i ||
                obs_opc[i] != int'(mem_opc[4+i])) begin
                n_fail++;
                $display("FAIL err_res[%0d]: data=%h err=%b addr=%0d opc=%0d, want %h/%b/%0d/%0d",
                         i, obs_data[i], obs_err[i], obs_addr[i], obs_opc[i], exp_d[i], exp_e[i],
                         4 + i, mem_opc[4+i]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [63:0] sd;
        logic [PW-1:0] sa;
        int waited;
        set_loc(10, 4'd3, 32'd100, 32'd23);
        set_loc(11, 4'd2, 32'd1, -32'sd50);
        i_res_ready = 1'b0;
        do_start(10, 2);
        waited = 0;
        while (!o_res_valid && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        n_cmp++;
        if (!o_res_valid) begin
            n_fail++;
            $display("FAIL bp_valid: valid=%b after %0d cycles, want 1", o_res_valid, waited);
        end
        sd = o_res_data;
        sa = o_res_addr;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_cmp++;
            if (o_res_valid !== 1'b1 || o_res_data !== 64'd123 || o_res_addr !== 5'd10 ||
                o_res_data !== sd || o_res_addr !== sa || o_read_pointer !== 5'd10) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: valid=%b data=%h addr=%0d ptr=%0d, want 1/7b/10/10",
                         i, o_res_valid, o_res_data, o_res_addr, o_read_pointer);
            end
        end
        i_res_ready = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (o_res_valid !== 1'b0 || o_read_pointer !== 5'd11) begin
            n_fail++;
            $display("FAIL bp_accept: valid=%b ptr=%0d, want 0/11", o_res_valid, o_read_pointer);
        end
        collect(1, 0, 1'b0);
        n_cmp++;
        if (obs_data.size() != 1 || obs_addr[0] != 11 || obs_data[0] !== -64'sd50 ||
            done_cnt != 1) begin
            n_fail++;
            $display("FAIL bp_rest: results=%0d addr=%0d data=%h done=%0d, want 1/11/-50/1",
                     obs_data.size(), obs_addr[0], obs_data[0], done_cnt);
        end
    endtask

    task automatic test_wrap_busy();
        logic [63:0] ed;
        logic        ee;
        set_loc(31, 4'd3, $urandom, $urandom);
        set_loc(0, 4'd4, $urandom, $urandom);
        do_start(31, 2);
        collect(2, 25, 1'b1);
        n_cmp++;
        if (obs_data.size() != 2 || done_cnt != 1) begin
            n_fail++;
            $display("FAIL wrap_count: results=%0d done=%0d, want 2/1", obs_data.size(), done_cnt);
        end
        for (int i = 0; i < 2 && i < obs_data.size(); i++) begin
            int ad;
            ad = (31 + i) % DEPTH;
            model(mem_opc[ad], mem_a[ad], mem_b[ad], ed, ee);
            n_cmp++;
            if (obs_addr[i] != ad || obs_data[i] !== ed || obs_err[i] !== ee) begin
                n_fail++;
                $display("FAIL wrap_res[%0d]: addr=%0d data=%h err=%b, want %0d/%h/%b",
                         i, obs_addr[i], obs_data[i], obs_err[i], ad, ed, ee);
            end
        end
        n_cmp++;
        if (unstable != 0) begin
            n_fail++;
            $display("FAIL wrap_stall_hold: %0d changes while stalled, want 0", unstable);
        end
        repeat (3) @(negedge clk);
        n_cmp++;
        if (o_busy !== 1'b0 || o_res_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_start_ignored: busy=%b valid=%b, want 0/0", o_busy, o_res_valid);
        end
    endtask

    task automatic test_count_zero();
        do_start(3, 0);
        n_cmp++;
        if (o_done !== 1'b1 || o_busy !== 1'b0 || o_res_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_e0: done=%b busy=%b valid=%b, want 1/0/0",
                     o_done, o_busy, o_res_valid);
        end
        @(negedge clk);
        n_cmp++;
        if (o_done !== 1'b0 || o_busy !== 1'b0 || o_res_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_after: done=%b busy=%b valid=%b, want 0/0/0",
                     o_done, o_busy, o_res_valid);
        end
    endtask

    task automatic test_reset_mid();
        int   waited;
        int   seen_done;
        logic [63:0] ed;
        logic        ee;
        for (int i = 0; i < 3; i++) set_loc(i, 4'($urandom_range(7)), $urandom, $urandom);
        i_res_ready = 1'b0;
        do_start(0, 3);
        waited = 0;
        while (!o_res_valid && waited < 10) begin @(negedge clk); waited++; end
        i_res_ready = 1'b1;
        @(negedge clk);
        i_res_ready = 1'b0;
        while (!o_res_valid && waited < 20) begin @(negedge clk); waited++; end
        n_cmp++;
        if (!o_res_valid || o_res_addr !== 5'd1) begin
            n_fail++;
            $display("FAIL rmid_second: valid=%b addr=%0d, want 1/1", o_res_valid, o_res_addr);
        end
        #1 i_reset = 1'b1;
        #1;
        n_cmp++;
        if ({o_read_pointer, o_busy, o_res_valid, o_res_data, o_res_addr, o_res_opc,
             o_res_err, o_done} !== '0) begin
            n_fail++;
            $display("FAIL rmid_async: ptr=%0d busy=%b valid=%b data=%h addr=%0d, want 0",
                     o_read_pointer, o_busy, o_res_valid, o_res_data, o_res_addr);
        end
        @(negedge clk);
        i_reset = 1'b0;
        i_res_ready = 1'b1;
        seen_done = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (o_done || o_res_valid || o_busy) seen_done++;
        end
        n_cmp++;
        if (seen_done != 0) begin
            n_fail++;
            $display("FAIL rmid_quiet: %0d active cycles after reset, want 0", seen_done);
        end
        do_start(0, 3);
        collect(3, 0, 1'b0);
        n_cmp++;
        if (obs_data.size() != 3 || done_cnt != 1) begin
            n_fail++;
            $display("FAIL rmid_restart: results=%0d done=%0d, want 3/1", obs_data.size(), done_cnt);
        end
        for (int i = 0; i < 3 && i < obs_data.size(); i++) begin
            model(mem_opc[i], mem_a[i], mem_b[i], ed, ee);
            n_cmp++;
            if (obs_addr[i] != i || obs_data[i] !== ed || obs_err[i] !== ee) begin
                n_fail++;
                $display("FAIL rmid_res[%0d]: addr=%0d data=%h err=%b, want %0d/%h/%b",
                         i, obs_addr[i], obs_data[i], obs_err[i], i, ed, ee);
            end
        end
    endtask

    task automatic test_corner();
        logic [63:0] exp_d [3];
        exp_d[0] = 64'h3FFFFFFF00000001;
        exp_d[1] = -64'sd4;
        exp_d[2] = 64'h0000000080000000;
        set_loc(20, 4'd5, 32'h7FFFFFFF, 32'h7FFFFFFF);
        set_loc(21, 4'd6, -32'sd9, 32'd2);
        set_loc(22, 4'd6, 32'h80000000, 32'hFFFFFFFF);
        do_start(20, 3);
        collect(3, 10, 1'b0);
        n_cmp++;
        if (obs_data.size() != 3) begin
            n_fail++;
            $display("FAIL corner_count: results=%0d, want 3", obs_data.size());
        end
        for (int i = 0; i < 3 && i < obs_data.size(); i++) begin
            n_cmp++;
            if (obs_data[i] !== exp_d[i] || obs_err[i] !== 1'b0) begin
                n_fail++;
                $display("FAIL corner_res[%0d]: data=%h err=%b, want %h/0",
                         i, obs_data[i], obs_err[i], exp_d[i]);
            end
        end
    endtask

    task automatic test_random();
        logic [63:0] ed;
        logic        ee;
        int          ptr;
        int          cnt;
        for (int it = 0; it < 6; it++) begin
            for (int ad = 0; ad < DEPTH; ad++) begin
                logic [3:0]  op;
                logic [31:0] a;
                logic [31:0] b;
                op = ($urandom_range(9) < 8) ? 4'($urandom_range(7)) : 4'($urandom_range(15));
                a  = ($urandom_range(3) == 0) ? 32'($signed($urandom_range(6)) - 3) : $urandom;
                b  = ($urandom_range(3) == 0) ? 32'($signed($urandom_range(6)) - 3) : $urandom;
                set_loc(ad, op, a, b);
            end
            ptr = $urandom_range(DEPTH - 1);
            cnt = (it == 0) ? DEPTH : $urandom_range(DEPTH, 1);
            do_start(ptr, cnt);
            collect(cnt, 30, 1'b0);
            n_cmp++;
            if (timed_out || obs_data.size() != cnt || done_cnt != 1 || unstable != 0) begin
                n_fail++;
                $display("FAIL rand%0d_run: results=%0d/%0d done=%0d unstable=%0d timeout=%b",
                         it, obs_data.size(), cnt, done_cnt, unstable, timed_out);
            end
            for (int i = 0; i < cnt && i < obs_data.size(); i++) begin
                int ad;
                ad = (ptr + i) % DEPTH;
                model(mem_opc[ad], mem_a[ad], mem_b[ad], ed, ee);
                n_cmp++;
                if (obs_addr[i] != ad || obs_opc[i] != int'(mem_opc[ad]) ||
                    obs_data[i] !== ed || obs_err[i] !== ee) begin
                    n_fail++;
                    $display("FAIL rand%0d_res[%0d]: addr=%0d opc=%0d data=%h err=%b, want %0d/%0d/%h/%b",
                             it, i, obs_addr[i], obs_opc[i], obs_data[i], obs_err[i],
                             ad, mem_opc[ad], ed, ee);
                end
            end
        end
    endtask

    initial begin
        for (int ad = 0; ad < DEPTH; ad++) set_loc(ad, 4'd0, 32'd0, 32'd0);
        test_reset();
        test_basic();
        test_errors();
        test_backpressure();
        test_wrap_busy();
        test_count_zero();
        test_reset_mid();
        test_corner();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_reader_exec.md
# instr_reader_exec

Read-side consumer for the instruction register. On a start command it walks a programmed range of register locations via `read_pointer`, captures each `instruction_word`, executes the opcode on the two operands and presents one result per location on a valid/ready output port. It sits beside the instruction register as the reading and executing end of the path that the write side (`load_en`/`write_pointer`) fills.

## Interface
- `DEPTH`, 32: number of register locations; pointer width `PW = $clog2(DEPTH)`.
- `OPW`, 32: operand width (signed); result width is `2*OPW`.
- `clk`  in  1  sole clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `start`  in  1  command pulse; sampled only in IDLE.
- `start_ptr`  in  PW  first location to read.
- `count`  in  PW+1  number of locations to process, 0..DEPTH.
- `read_pointer`  out  PW  address driven to the instruction register.
- `iw_opc`  in  4  `instruction_word.opc`, combinationally valid for the current `read_pointer`.
- `iw_op_a`  in  OPW  `instruction_word.op_a`, signed.
- `iw_op_b`  in  OPW  `instruction_word.op_b`, signed.
- `busy`  out  1  high whenever the FSM is not in IDLE.
- `res_valid`  out  1  result is presented.
- `res_ready`  in  1  downstream accepts the result.
- `res_data`  out  2*OPW  signed result.
- `res_addr`  out  PW  location the result came from.
- `res_opc`  out  4  opcode executed.
- `res_err`  out  1  divide/mod by zero or illegal opcode.
- `done`  out  1  one-cycle pulse after the last result is accepted.

## Operation
- States: IDLE, FETCH, EXEC, RESP.
- IDLE: `start`=1 latches `start_ptr` into `read_pointer` and `count` into the remaining counter. If `count`=0, stay in IDLE and pulse `done`; otherwise go to FETCH.
- FETCH: `read_pointer` is stable; on the next edge latch `iw_opc`/`iw_op_a`/`iw_op_b` and `read_pointer`, then go to EXEC.
- EXEC: compute the result, register it into `res_*`, set `res_valid`, then go to RESP.
- RESP: hold all `res_*` stable while `res_valid`=1 and `res_ready`=0.
  - On an edge with `res_ready`=1, clear `res_valid` and decrement remaining.
  - If remaining was 1, go to IDLE and pulse `done`.
  - Otherwise increment `read_pointer` modulo DEPTH and go to FETCH.
- Opcode encoding and results (operands sign-extended to 2*OPW):
  - 0 ZERO: 0.
  - 1 PASSA: a.
  - 2 PASSB: b.
  - 3 ADD: a+b.
  - 4 SUB: a−b.
  - 5 MULT: full signed a*b.
  - 6 DIV: a/b, truncated toward zero.
  - 7 MOD: a%b, result takes the sign of the dividend.
- Error results: DIV or MOD with b=0, and opcodes 8..15, give `res_data`=0 and `res_err`=1. Otherwise `res_err`=0.
- `start` is ignored while `busy`=1.
- Pointer wrap: with `start_ptr`=DEPTH−1, the next location read is 0.
- `count`=DEPTH reads every location exactly once.

## Timing
- Reset values: `read_pointer`=0, `busy`=0, `res_valid`=0, `res_data`=0, `res_addr`=0, `res_opc`=0, `res_err`=0, `done`=0, state=IDLE.
- `reset` asserted mid-operation aborts the sequence immediately. No `done` is generated and no partial result is held.
- Let E0 be the edge that accepts `start`.
  - `read_pointer`=`start_ptr` after E0.
  - Operands are captured at E1.
  - `res_valid`=1 after E2.
- With `res_ready` held high, one result is produced every 3 cycles.
- The accepting edge and the next FETCH coincide: the next `read_pointer` appears after the accepting edge.
- `done` is high for exactly one cycle, after the edge that accepts the last result. `busy` falls on that same edge.
- For `count`=0, `done` is high for the one cycle after E0 and `busy` never rises.
- `iw_*` only needs to be valid in the FETCH cycle. Changes in other states have no effect.

## Test plan
- Reset, then `start_ptr`=0, `count`=3 with locations {ADD 5,3}, {SUB −7,2}, {MULT −4,6}, `res_ready`=1 → results 8, −9, −24 at addrs 0, 1, 2; `done` one cycle after the third; first `res_valid` 2 cycles after the start edge.
- Location 4 = {DIV 7,0}, location 5 = {MOD −7,2}, location 6 = opcode 12 → results 0/err=1, −1/err=0, 0/err=1.
- Backpressure: `res_ready`=0 for 5 cycles on the first result → `res_*` stable throughout, `read_pointer` unchanged, exactly one acceptance.
- `start_ptr`=31, `count`=2 → addrs 31 then 0. A `start` pulse while busy is ignored. `count`=0 → `done` pulse and no `res_valid`.
- Assert `reset` during RESP of the second of 3 results → all outputs go to reset values immediately; no `done`; a fresh start works normally.
- {MULT 32'h7FFFFFFF, 32'h7FFFFFFF} → 64'h3FFFFFFF00000001; {DIV −9,2} → −4.
